// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A start/done handshake issues one division and returns the quotient and
// remainder N+1 edges after the accepting edge; a zero divisor short-cuts
// to a saturated quotient with the dividend as remainder.
module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  // S_LAST is the settling cycle between the final iteration and the done
  // pulse; the result registers load on its exit so done lines up with them.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [N:0]    r_reg;
  logic [CW-1:0] count;
  logic          zero_div;
  logic [N:0]    r_shift;
  logic [N:0]    trial;
  logic          accept;

  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
  assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
  assign trial   = r_shift - {1'b0, d_reg};
  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);

  // Next-state selection for the handshake sequence
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = (divisor == '0) ? S_LAST : S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (count == LAST_COUNT) begin
          state_next = S_LAST;
        end
      end
      S_LAST: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture and one shift/subtract iteration per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      count    <= '0;
      zero_div <= 1'b0;
    end else if (accept) begin
      q_reg    <= dividend;
      d_reg    <= divisor;
      r_reg    <= '0;
      count    <= '0;
      zero_div <= (divisor == '0);
    end else if (state == S_RUN) begin
      if (!trial[N]) begin
        r_reg <= trial;
        q_reg <= {q_reg[N-2:0], 1'b1};
      end else begin
        r_reg <= r_shift;
        q_reg <= {q_reg[N-2:0], 1'b0};
      end
      count <= count + CW'(1);
    end
  end

  // Result registers hold the last completed division until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == S_LAST) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= q_reg;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= q_reg;
        remainder   <= r_reg[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
